// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Owns the PC, issues reads to the icache, and presents a registered
// instruction and its PC+4 to decode. Handles stalls, flushes,
// branch/jump redirects (including a redirect that arrives while a fetch
// is still outstanding) and halt.
//
// Ports:
//   CLK, nRST         clock (rising edge), async active-low reset
//   ihit, iload       icache hit and returned instruction word
//   stall, flush      hazard-unit hold / squash of IF/ID
//   redirect,
//   redirect_pc       one-cycle taken branch/jump and its target
//   halt_in           stop fetching (left only through reset)
//   iREN, iaddr       icache read request and address (= pc)
//   if_instr, if_npc,
//   if_valid          IF/ID register contents to decode
//   pend              a redirect is waiting for the outstanding fetch
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_in,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] if_instr,
    output logic [31:0] if_npc,
    output logic        if_valid,
    output logic        pend
);

    typedef enum logic [0:0] {FETCH, HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pend_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_npc_nxt;
    logic        w_valid_nxt;
    logic        w_bubble;
    logic        w_load;
    logic [31:0] w_pc_plus4;

    // 32-bit modulo add: wraps 0xFFFF_FFFC to 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_bubble      = 1'b0;
        w_load        = 1'b0;
        iREN          = 1'b0;

        case (r_state)
            FETCH: begin
                iREN = 1'b1;
                if (halt_in) begin
                    w_state_nxt = HALTED;
                    w_bubble    = 1'b1;
                end else if (redirect && !ihit) begin
                    // Fetch still outstanding: keep iaddr stable and park
                    // the target until the icache answers.
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = redirect_pc;
                    w_bubble      = 1'b1;
                end else if (redirect) begin
                    w_pc_nxt   = redirect_pc;
                    w_pend_nxt = 1'b0;
                    w_bubble   = 1'b1;
                end else if (r_pend && ihit) begin
                    // Returned word belongs to the wrong path; drop it.
                    w_pc_nxt   = r_pend_pc;
                    w_pend_nxt = 1'b0;
                    w_bubble   = !stall || flush;
                end else begin
                    if (ihit && !stall) begin
                        w_pc_nxt = w_pc_plus4;
                        w_load   = 1'b1;
                    end else if (!ihit && !stall) begin
                        w_bubble = 1'b1;
                    end
                    // Flush squashes IF/ID even under stall; pc still
                    // follows the normal hit/stall rules above.
                    if (flush) begin
                        w_bubble = 1'b1;
                        w_load   = 1'b0;
                    end
                end
            end
            HALTED: ;
            default: w_state_nxt = FETCH;
        endcase

        w_instr_nxt = r_instr;
        w_npc_nxt   = r_npc;
        w_valid_nxt = r_valid;
        if (w_bubble) begin
            w_instr_nxt = NOP_INSTR;
            w_npc_nxt   = 32'd0;
            w_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_instr_nxt = iload;
            w_npc_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= FETCH;
            r_pc      <= PC_INIT;
            r_pend    <= 1'b0;
            r_pend_pc <= 32'd0;
            r_instr   <= NOP_INSTR;
            r_npc     <= 32'd0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_npc     <= w_npc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign iaddr    = r_pc;
    assign if_instr = r_instr;
    assign if_npc   = r_npc;
    assign if_valid = r_valid;
    assign pend     = r_pend;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, flush, redirect, halt_in;
    logic [31:0] iload, redirect_pc;
    logic        iREN, if_valid, pend;
    logic [31:0] iaddr, if_instr, if_npc;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .stall(stall),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt_in(halt_in), .iREN(iREN), .iaddr(iaddr), .if_instr(if_instr),
        .if_npc(if_npc), .if_valid(if_valid), .pend(pend)
    );

    typedef struct packed {
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        flush;
        logic        stall;
        logic        ihit;
        logic [31:0] iload;
    } in_t;

    typedef struct packed {
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        pend;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic in_t I(logic h, logic r, logic [31:0] rpc, logic f,
                              logic s, logic ih, logic [31:0] ld);
        in_t v;
        v.halt = h; v.redir = r; v.rpc = rpc; v.flush = f;
        v.stall = s; v.ihit = ih; v.iload = ld;
        return v;
    endfunction

    function automatic out_t O(logic en, logic [31:0] a, logic [31:0] ins,
                               logic [31:0] npc, logic vld, logic pd);
        out_t v;
        v.iren = en; v.iaddr = a; v.instr = ins;
        v.npc = npc; v.valid = vld; v.pend = pd;
        return v;
    endfunction

    function automatic void add(in_t i, out_t o);
        vec_t v;
        v.in  = i;
        v.exp = o;
        tbl.push_back(v);
    endfunction

    task automatic drive(in_t i);
        halt_in = i.halt; redirect = i.redir; redirect_pc = i.rpc;
        flush = i.flush; stall = i.stall; ihit = i.ihit; iload = i.iload;
    endtask

    task automatic check(string name, out_t exp);
        out_t got;
        got = O(iREN, iaddr, if_instr, if_npc, if_valid, pend);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got iREN=%0b iaddr=%h instr=%h npc=%h valid=%0b pend=%0b, want iREN=%0b iaddr=%h instr=%h npc=%h valid=%0b pend=%0b",
                      name, got.iren, got.iaddr, got.instr, got.npc, got.valid, got.pend,
                      exp.iren, exp.iaddr, exp.instr, exp.npc, exp.valid, exp.pend);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(in_t i);
        drive(i);
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] X = 32'hDEAD_BEEF;

    initial begin
        // idle / reset inputs
        drive(I(0, 0, 0, 0, 0, 0, 0));
        nRST = 1'b0;
        #12;
        check("reset", O(1, 32'h0, 32'h0, 32'h0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;

        //    halt redir rpc  flush stall ihit iload          iREN iaddr  instr  npc  valid pend
        // straight-line fetch
        add(I(0, 0, 0, 0, 0, 1, 32'h2001_0005), O(1, 32'h4, 32'h2001_0005, 32'h4, 1, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h2002_0007), O(1, 32'h8, 32'h2002_0007, 32'h8, 1, 0));
        // stall with hit: everything holds, returned word dropped
        add(I(0, 0, 0, 0, 1, 1, X), O(1, 32'h8, 32'h2002_0007, 32'h8, 1, 0));
        add(I(0, 0, 0, 0, 1, 1, X), O(1, 32'h8, 32'h2002_0007, 32'h8, 1, 0));
        add(I(0, 0, 0, 0, 1, 1, X), O(1, 32'h8, 32'h2002_0007, 32'h8, 1, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h2003_0001), O(1, 32'hC, 32'h2003_0001, 32'hC, 1, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h2004_0002), O(1, 32'h10, 32'h2004_0002, 32'h10, 1, 0));
        // redirect with hit
        add(I(0, 1, 32'h40, 0, 0, 1, 32'hBAD0_0001), O(1, 32'h40, 32'h0, 32'h0, 0, 0));
        // miss without stall -> bubble, pc holds
        add(I(0, 0, 0, 0, 0, 0, X), O(1, 32'h40, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h1111_2222), O(1, 32'h44, 32'h1111_2222, 32'h44, 1, 0));
        add(I(0, 1, 32'h20, 0, 0, 1, X), O(1, 32'h20, 32'h0, 32'h0, 0, 0));
        // redirect during miss; newer target overwrites pend_pc
        add(I(0, 1, 32'h60, 0, 0, 0, X), O(1, 32'h20, 32'h0, 32'h0, 0, 1));
        add(I(0, 1, 32'h80, 0, 0, 0, X), O(1, 32'h20, 32'h0, 32'h0, 0, 1));
        add(I(0, 0, 0, 0, 0, 0, X), O(1, 32'h20, 32'h0, 32'h0, 0, 1));
        add(I(0, 0, 0, 0, 0, 1, 32'hBAD0_0002), O(1, 32'h80, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h2222_3333), O(1, 32'h84, 32'h2222_3333, 32'h84, 1, 0));
        // PC wrap
        add(I(0, 1, 32'hFFFF_FFFC, 0, 0, 1, X), O(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h3333_4444), O(1, 32'h0, 32'h3333_4444, 32'h0, 1, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h4444_5555), O(1, 32'h4, 32'h4444_5555, 32'h4, 1, 0));
        // flush under stall: bubble, pc holds; flush without stall: pc advances
        add(I(0, 0, 0, 1, 1, 1, X), O(1, 32'h4, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 1, 0, 1, 32'h5555_0000), O(1, 32'h8, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h6666_7777), O(1, 32'hC, 32'h6666_7777, 32'hC, 1, 0));
        // redirect overrides stall
        add(I(0, 1, 32'h100, 0, 1, 1, X), O(1, 32'h100, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h7777_0000), O(1, 32'h104, 32'h7777_0000, 32'h104, 1, 0));
        // miss + stall holds everything; miss alone bubbles
        add(I(0, 0, 0, 0, 1, 0, X), O(1, 32'h104, 32'h7777_0000, 32'h104, 1, 0));
        add(I(0, 0, 0, 0, 0, 0, X), O(1, 32'h104, 32'h0, 32'h0, 0, 0));
        // pend resolved while stalled: pc still redirects
        add(I(0, 1, 32'h200, 0, 0, 0, X), O(1, 32'h104, 32'h0, 32'h0, 0, 1));
        add(I(0, 0, 0, 0, 1, 1, X), O(1, 32'h200, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h8888_9999), O(1, 32'h204, 32'h8888_9999, 32'h204, 1, 0));
        // halt beats redirect/hit; then frozen
        add(I(1, 1, 32'h300, 0, 0, 1, X), O(0, 32'h204, 32'h0, 32'h0, 0, 0));
        add(I(0, 1, 32'h400, 0, 0, 1, X), O(0, 32'h204, 32'h0, 32'h0, 0, 0));
        add(I(0, 1, 32'h500, 0, 0, 0, X), O(0, 32'h204, 32'h0, 32'h0, 0, 0));
        add(I(0, 0, 0, 0, 0, 1, 32'h9999_0000), O(0, 32'h204, 32'h0, 32'h0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].in);
            check($sformatf("vec%0d", k), tbl[k].exp);
        end

        // reset while halted: async, takes effect before any edge
        @(negedge CLK);
        drive(I(0, 0, 0, 0, 0, 1, X));
        nRST = 1'b0;
        #1;
        check("halt_reset", O(1, 32'h0, 32'h0, 32'h0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        step(I(0, 0, 0, 0, 0, 1, 32'hABCD_0001));
        check("after_halt_reset", O(1, 32'h4, 32'hABCD_0001, 32'h4, 1, 0));

        // reset mid-fetch with a pending redirect: pend and its target are lost
        step(I(0, 1, 32'h50, 0, 0, 0, X));
        check("pend_set", O(1, 32'h4, 32'h0, 32'h0, 0, 1));
        #2;
        nRST = 1'b0;
        #1;
        check("midfetch_reset", O(1, 32'h0, 32'h0, 32'h0, 0, 0));
        @(negedge CLK);
        nRST = 1'b1;
        step(I(0, 0, 0, 0, 0, 1, 32'hCAFE_0001));
        check("after_midfetch_reset", O(1, 32'h4, 32'hCAFE_0001, 32'h4, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
